// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the handshake transmit scheduler slice.
//   - Default widths and the watchdog limit used by hs_tx_scheduler.
//   - FSM state encoding, shared by the scheduler and anything that
//     decodes its state.
// ---------------------------------------------------------------------------
package hs_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int TAG_W_DEF  = 2;
    localparam int DATA_W_DEF = 6;
    localparam int WIDTH_DEF  = 8;
    localparam int TO_CYC_DEF = 255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. It picks the first asserted request at
// or after the priority pointer, wrapping cyclically.
// Ports:
//   valid_i  in  N_REQ  request vector
//   ptr_i    in  IDX_W  index that has highest priority this cycle
//   grant_o  out N_REQ  one-hot grant (all zero when nothing is valid)
//   idx_o    out IDX_W  index of the granted requester
//   any_o    out 1      some requester is valid
// ---------------------------------------------------------------------------
module rr_arbiter
    import hs_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Walk the requesters starting at the pointer. N_REQ is a power of two,
    // so the natural IDX_W-bit wrap of ptr+k gives the cyclic order. The
    // first valid candidate wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_i + IDX_W'(k);
            if (!any_o && valid_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        grant_o[idx_o] = any_o;
    end

endmodule

// File: rtl/hs_tx_scheduler.sv
// ---------------------------------------------------------------------------
// hs_tx_scheduler
// Shares one handshake-synchronizer transmit channel among N_REQ requesters.
// A round-robin winner has its payload tagged with its index. The tagged
// word is issued for one cycle, and no further issue happens until the
// channel pulses sidle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester valid
//   req_data     packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot accept (combinational, only in IDLE)
//   sready       one-cycle issue pulse to the channel
//   din          {tag, payload}, valid while sready is high
//   sidle        channel-idle pulse, honoured only while waiting
//   busy         scheduler is not idle
//   timeout_err  sticky watchdog flag, cleared only by rst
//   xfer_cnt     wrapping count of issued transfers
// ---------------------------------------------------------------------------
module hs_tx_scheduler
    import hs_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    sready,
    output logic [WIDTH-1:0]        din,
    input  logic                    sidle,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             xfer_cnt
);

    localparam int WD_W = $clog2(TO_CYC + 1);

    logic [1:0]       state_q,   state_d;
    logic [TAG_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [WD_W-1:0]  wd_cnt_q,  wd_cnt_d;
    logic [WIDTH-1:0] din_q,     din_d;
    logic [15:0]      xfer_q,    xfer_d;
    logic             timeout_q, timeout_d;
    logic             sready_q,  sready_d;
    logic             busy_q,    busy_d;

    logic [N_REQ-1:0] gnt;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (TAG_W)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Requesters are accepted only while IDLE, so they stall during ISSUE
    // and WAIT without any extra handshake.
    assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

    // Next-state logic. sready and busy are computed from the next state
    // so that they come straight from flops and line up with the state.
    // The watchdog raises timeout_err on the increment that brings wd_cnt
    // to TO_CYC, then holds the count there.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = wd_cnt_q;
        din_d     = din_q;
        xfer_d    = xfer_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    din_d    = {gnt_idx, req_data[gnt_idx*DATA_W +: DATA_W]};
                    rr_ptr_d = gnt_idx + TAG_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                xfer_d   = xfer_q + 16'd1;
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (sidle) begin
                    state_d = ST_IDLE;
                end else if (wd_cnt_q != WD_W'(TO_CYC)) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    if (wd_cnt_d == WD_W'(TO_CYC)) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sready_d = (state_d == ST_ISSUE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers. A reset in the middle of a transfer
    // returns to IDLE at once. Anything still inside the channel is
    // forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
            din_q     <= '0;
            xfer_q    <= '0;
            timeout_q <= 1'b0;
            sready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            din_q     <= din_d;
            xfer_q    <= xfer_d;
            timeout_q <= timeout_d;
            sready_q  <= sready_d;
            busy_q    <= busy_d;
        end
    end

    assign sready      = sready_q;
    assign din         = din_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;
    assign xfer_cnt    = xfer_q;

endmodule

// File: tb/tb_hs_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hs_tx_scheduler
// Directed bench for hs_tx_scheduler with the default parameters
// (4 requesters, 2-bit tag, 6-bit payload, watchdog limit 255).
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_hs_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_data;
    logic [3:0]  req_ready;
    logic        sready;
    logic [7:0]  din;
    logic        sidle;
    logic        busy;
    logic        timeout_err;
    logic [15:0] xfer_cnt;

    int vectors     = 0;
    int miscompares = 0;

    hs_tx_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .sready      (sready),
        .din         (din),
        .sidle       (sidle),
        .busy        (busy),
        .timeout_err (timeout_err),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle 1 ns before anyone drives or samples.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle sidle pulse that is sampled on the next edge.
    task automatic pulse_sidle();
        sidle = 1'b1;
        step();
        sidle = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        sidle     = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Reset values, then a single request from requester 0.
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy, sready, timeout_err} !== 3'b000 || din !== 8'h00 || xfer_cnt !== 16'd0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: busy=%b sready=%b to=%b din=%h cnt=%0d rdy=%b, want all zero",
                     busy, sready, timeout_err, din, xfer_cnt, req_ready);
        end
    endtask

    task automatic test_single();
        req_data       = 24'h0;
        req_data[5:0]  = 6'h2A;
        req_valid      = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (sready !== 1'b1 || din !== 8'h2A || busy !== 1'b1 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_issue: sready=%b din=%h busy=%b rdy=%b want 1 2a 1 0000",
                     sready, din, busy, req_ready);
        end
        step();
        vectors++;
        if (sready !== 1'b0 || xfer_cnt !== 16'd1 || busy !== 1'b1 || din !== 8'h2A) begin
            miscompares++;
            $display("[TB] FAIL single_wait: sready=%b cnt=%0d busy=%b din=%h want 0 1 1 2a",
                     sready, xfer_cnt, busy, din);
        end
        step();
        step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_busy_hold: got %b want 1", busy);
        end
        pulse_sidle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    // All four requesters valid. Grants must rotate 0,1,2,3,0 and carry
    // matching tags. Payload of requester i is 6'h10+i.
    task automatic test_round_robin();
        logic [1:0] exp_idx;
        do_reset();
        req_data  = {6'h13, 6'h12, 6'h11, 6'h10};
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_idx = 2'(n);
            #1;
            vectors++;
            if (req_ready !== (4'b0001 << exp_idx)) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got %b want %b", n, req_ready, 4'b0001 << exp_idx);
            end
            step();
            vectors++;
            if (sready !== 1'b1 || din !== {exp_idx, 4'h4, exp_idx}) begin
                miscompares++;
                $display("[TB] FAIL rr_din%0d: sready=%b din=%h want 1 %h", n, sready, din, {exp_idx, 4'h4, exp_idx});
            end
            step();
            step();
            pulse_sidle();
        end
        req_valid = 4'b0000;
        vectors++;
        if (xfer_cnt !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL rr_count: got %0d want 5", xfer_cnt);
        end
    endtask

    // Requester 2 arrives while the block is waiting. It must stall until
    // the cycle after sidle. The pointer is 1 after the round-robin test.
    task automatic test_back_to_back();
        req_data  = {6'h13, 6'h05, 6'h11, 6'h10};
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL b2b_stall%0d: got %b want 0000", i, req_ready);
            end
            step();
        end
        pulse_sidle();
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL b2b_grant: got %b want 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (sready !== 1'b1 || din !== 8'h85) begin
            miscompares++;
            $display("[TB] FAIL b2b_din: sready=%b din=%h want 1 85", sready, din);
        end
        step();
        pulse_sidle();
    endtask

    // No sidle for a long time: the flag must be clear well before the
    // limit, set after it, and sticky across a late sidle. Pointer is 3.
    task automatic test_watchdog();
        req_data  = {6'h3F, 6'h05, 6'h11, 6'h01};
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        step();
        for (int i = 0; i < 200; i++) step();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wd_early: got %b want 0", timeout_err);
        end
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wd_set: to=%b busy=%b want 1 1", timeout_err, busy);
        end
        pulse_sidle();
        vectors++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wd_late_sidle: busy=%b to=%b want 0 1", busy, timeout_err);
        end
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL wd_next_grant: got %b want 1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (sready !== 1'b1 || din !== 8'hFF || timeout_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wd_next_issue: sready=%b din=%h to=%b want 1 ff 1", sready, din, timeout_err);
        end
        step();
        pulse_sidle();
    endtask

    // sidle while idle with nobody requesting must change nothing.
    task automatic test_spurious_sidle();
        pulse_sidle();
        vectors++;
        if (busy !== 1'b0 || sready !== 1'b0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL spurious_sidle: busy=%b sready=%b rdy=%b want 0 0 0000", busy, sready, req_ready);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || sready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL spurious_after: busy=%b sready=%b want 0 0", busy, sready);
        end
    endtask

    // Reset while waiting. Afterwards the pointer must be back at 0, so
    // with requesters 0 and 3 both valid the grant goes to 0. Without the
    // reset the pointer would be 2 and the grant would go to 3.
    task automatic test_reset_mid();
        req_data  = {6'h15, 6'h05, 6'h11, 6'h01};
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || xfer_cnt !== 16'd0 || sready !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid: busy=%b cnt=%0d sready=%b to=%b want 0 0 0 0",
                     busy, xfer_cnt, sready, timeout_err);
        end
        req_valid = 4'b1001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL rst_ptr: got %b want 0001", req_ready);
        end
        req_valid = 4'b1000;
        #1;
        step();
        req_valid = 4'b0000;
        vectors++;
        if (sready !== 1'b1 || din !== 8'hD5) begin
            miscompares++;
            $display("[TB] FAIL rst_req3: sready=%b din=%h want 1 d5", sready, din);
        end
        step();
        vectors++;
        if (xfer_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL rst_count: got %0d want 1", xfer_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        sidle     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_watchdog();
        test_spurious_sidle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
